// File: rtl/fifo_multichannel_pkg.sv
// Shared constants and helpers for the multi-channel FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Ceil-log2 clamped to at least 1 so single-entry selects still get a bit.
    function automatic int safe_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_multichannel_if.sv
// Channel-addressed write/read bus plus per-channel status for fifo_multichannel.
interface fifo_multichannel_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CHANNELS   = 4
);
    localparam int CH_W  = safe_clog2(CHANNELS);
    localparam int CNT_W = safe_clog2(DEPTH) + 1;

    logic                      write_enable;
    logic [CH_W-1:0]           write_channel;
    logic [DATA_WIDTH-1:0]     write_data;
    logic                      read_enable;
    logic [CH_W-1:0]           read_channel;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      read_valid;
    logic [CHANNELS-1:0]       fifo_full;
    logic [CHANNELS-1:0]       fifo_empty;
    logic [CHANNELS-1:0]       fifo_almost_full;
    logic [CHANNELS*CNT_W-1:0] fill_level;
    logic                      error_clear;
    logic [CHANNELS-1:0]       overflow;
    logic [CHANNELS-1:0]       underflow;

    modport master (
        output write_enable, write_channel, write_data,
        output read_enable, read_channel, error_clear,
        input  read_data, read_valid, fifo_full, fifo_empty,
        input  fifo_almost_full, fill_level, overflow, underflow
    );

    modport slave (
        input  write_enable, write_channel, write_data,
        input  read_enable, read_channel, error_clear,
        output read_data, read_valid, fifo_full, fifo_empty,
        output fifo_almost_full, fill_level, overflow, underflow
    );

endinterface

// File: rtl/fifo_multichannel_channel.sv
// One queue of the multi-channel FIFO: storage, pointers, count and status.
// Sticky overflow/underflow registers exist only with FIFO_ERROR_FLAGS_EN.
module fifo_channel
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int PTR_W      = safe_clog2(DEPTH),
    parameter int CNT_W      = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  afull_o,
    output logic                  ovf_o,
    output logic                  udf_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_acc, rd_acc;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign afull_o = (cnt_q >= CNT_W'(AF_LEVEL));
    assign cnt_o   = cnt_q;

    // Acceptance sees only pre-edge flags; a full queue can still drain this cycle.
    assign wr_acc    = wr_en_i & ~full_o;
    assign rd_acc    = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

`ifdef FIFO_ERROR_FLAGS_EN
    logic ovf_q, udf_q;

    // A fresh error in the clearing cycle takes priority over the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~err_clr_i) | (wr_en_i & full_o);
            udf_q <= (udf_q & ~err_clr_i) | (rd_en_i & empty_o);
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: rtl/fifo_multichannel.sv
// Single-clock multi-channel FIFO: channel decode, read mux and registered read port.
// Optional sticky error flags via FIFO_ERROR_FLAGS_EN.
module fifo_multichannel
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    parameter int DEPTH             = DEFAULT_DEPTH,
    parameter int CHANNELS          = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
    input  logic               clock,
    input  logic               reset_n,
    fifo_multichannel_if.slave fifo_if
);
    localparam int CH_W  = safe_clog2(CHANNELS);
    localparam int PTR_W = safe_clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CHANNELS-1:0]                 wr_sel, rd_sel;
    logic [CHANNELS-1:0]                 ch_full, ch_empty, ch_afull, ch_ovf, ch_udf;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] ch_rdata;
    logic [CHANNELS-1:0][CNT_W-1:0]      ch_cnt;

    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_vld_q, rd_vld_d;

    // Indices at or beyond CHANNELS match no select line, so they vanish silently.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign wr_sel[c] = fifo_if.write_enable && (fifo_if.write_channel == CH_W'(c));
        assign rd_sel[c] = fifo_if.read_enable  && (fifo_if.read_channel  == CH_W'(c));

        fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_LEVEL   (ALMOST_FULL_LEVEL),
            .PTR_W      (PTR_W),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .wr_en_i   (wr_sel[c]),
            .wr_data_i (fifo_if.write_data),
            .rd_en_i   (rd_sel[c]),
            .err_clr_i (fifo_if.error_clear),
            .rd_data_o (ch_rdata[c]),
            .cnt_o     (ch_cnt[c]),
            .full_o    (ch_full[c]),
            .empty_o   (ch_empty[c]),
            .afull_o   (ch_afull[c]),
            .ovf_o     (ch_ovf[c]),
            .udf_o     (ch_udf[c])
        );
    end

    assign rd_acc = |(rd_sel & ~ch_empty);

    always_comb begin
        rdata_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_sel[c]) rdata_mux = ch_rdata[c];
        end
    end

    always_comb begin
        rd_vld_d  = rd_acc;
        rd_data_d = rd_acc ? rdata_mux : rd_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign fifo_if.read_data        = rd_data_q;
    assign fifo_if.read_valid       = rd_vld_q;
    assign fifo_if.fifo_full        = ch_full;
    assign fifo_if.fifo_empty       = ch_empty;
    assign fifo_if.fifo_almost_full = ch_afull;
    assign fifo_if.fill_level       = ch_cnt;
    assign fifo_if.overflow         = ch_ovf;
    assign fifo_if.underflow        = ch_udf;

endmodule
